// File: rtl/demux_pkg.sv
// demux_pkg: shared state encoding, default widths and one-hot decode for the demux dispatcher.
package demux_pkg;
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;
    localparam int DEF_SEL_W = 2;
    localparam int DEF_DATA_W = 2;
    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction
endpackage

// File: rtl/demux_dispatch_ctrl_sat_counter.sv
// sat_counter: increment-on-pulse counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk)
        count <= rst ? '0 : (inc && count != '1) ? count + 1'b1 : count;
endmodule

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: single-item dispatcher driving a shared demux select with per-channel handshake and stall timeout.
// Optional DEMUX_DISPATCH_RR_EN: destination taken from an internal round-robin pointer instead of in_dest.
module demux_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]   in_dest,
    output logic               in_ready,
    output logic [SEL_W-1:0]   sel,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               busy
);
    state_t state, state_n;
    logic [7:0] timer;
    logic [SEL_W-1:0] dest;
    logic bad, accept, err_inc, done, drop, hit;

`ifdef DEMUX_DISPATCH_RR_EN
    logic [SEL_W-1:0] rr;
    logic unused_dest;
    assign unused_dest = ^in_dest;
    assign dest = rr;
    assign bad = 1'b0;
    always_ff @(posedge clk)
        rr <= rst ? '0 : (done || drop) ? (32'(rr) == NUM_OUT - 1 ? '0 : rr + 1'b1) : rr;
`else
    assign dest = in_dest;
    assign bad = 32'(in_dest) >= 32'(NUM_OUT);
`endif

    assign busy = state == OFFER;
    assign in_ready = state == IDLE;
    assign out_valid = busy ? NUM_OUT'(onehot(32'(sel))) : '0;
    // only the selected channel's ready can complete, since out_valid is one-hot
    assign hit = |(out_ready & out_valid);

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        accept = 1'b0;
        err_inc = 1'b0;
        done = 1'b0;
        drop = 1'b0;
        if (state == IDLE) begin
            accept = in_valid && !bad;
            err_inc = in_valid && bad;
            state_n = accept ? OFFER : IDLE;
        end else begin
            done = hit;
            drop = !hit && timer == 8'(TIMEOUT - 1);
            state_n = (done || drop) ? IDLE : OFFER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= '0;
            out_data <= '0;
            timer <= '0;
        end else if (accept) begin
            sel <= dest;
            out_data <= in_data;
            timer <= '0;
        end else if (busy && !done && !drop) begin
            timer <= timer + 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_drop (.clk(clk), .rst(rst), .inc(drop), .count(drop_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_err (.clk(clk), .rst(rst), .inc(err_inc), .count(err_cnt));
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: table-driven bench with a transfer scoreboard; NUM_OUT=3, CNT_W=2 to reach invalid dest and saturation.
module tb_demux_dispatch_ctrl;
    localparam int NO = 3;
    localparam int TO = 15;

    logic clk = 0;
    logic rst;
    logic in_valid;
    logic [1:0] in_data;
    logic [1:0] in_dest;
    logic in_ready;
    logic [1:0] sel;
    logic [1:0] out_data;
    logic [NO-1:0] out_valid;
    logic [NO-1:0] out_ready;
    logic [1:0] drop_cnt;
    logic [1:0] err_cnt;
    logic busy;

    int n_tests = 0;
    int n_fail = 0;
    logic [4:0] q[$];

    always #5 clk = ~clk;

    demux_dispatch_ctrl #(.DATA_W(2), .NUM_OUT(NO), .SEL_W(2), .TIMEOUT(TO), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
        .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .drop_cnt(drop_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    function automatic logic [NO-1:0] oh(input int d);
        logic [NO-1:0] r;
        r = '0;
        r[d] = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] d, input logic [1:0] t);
        in_valid = 1'b1;
        in_data = d;
        in_dest = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // scoreboard: every completed handshake must match the oldest expected item
    always @(negedge clk) begin
        if (!rst && (out_valid & out_ready) != 0) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL xfer: unexpected transfer data %0h valid %0h", out_data, out_valid);
            end else begin
                check("xfer", {out_data, out_valid}, q.pop_front());
            end
        end
    end

    typedef struct {
        logic [1:0] data;
        logic [1:0] dest;
        int rdy_at;
        logic [NO-1:0] mask;
        int kind;
        int len;
        int drops;
        int errs;
    } vec_t;

    vec_t vt[13];
    int len;
    int last_sel;

    initial begin
        vt[0]  = '{2'd2, 2'd2,  0, 3'b100, 0,  1, 0, 0};
        vt[1]  = '{2'd1, 2'd0,  3, 3'b001, 0,  4, 0, 0};
        vt[2]  = '{2'd3, 2'd1, 14, 3'b010, 0, 15, 0, 0};
        vt[3]  = '{2'd1, 2'd1, -1, 3'b000, 1, 15, 1, 0};
        vt[4]  = '{2'd3, 2'd3, -1, 3'b000, 2,  0, 1, 1};
        vt[5]  = '{2'd0, 2'd0,  0, 3'b110, 1, 15, 2, 1};
        vt[6]  = '{2'd2, 2'd2, 15, 3'b100, 1, 15, 3, 1};
        vt[7]  = '{2'd1, 2'd0, -1, 3'b000, 1, 15, 3, 1};
        vt[8]  = '{2'd2, 2'd1, -1, 3'b000, 1, 15, 3, 1};
        vt[9]  = '{2'd0, 2'd3, -1, 3'b000, 2,  0, 3, 2};
        vt[10] = '{2'd1, 2'd3, -1, 3'b000, 2,  0, 3, 3};
        vt[11] = '{2'd2, 2'd3, -1, 3'b000, 2,  0, 3, 3};
        vt[12] = '{2'd3, 2'd1,  1, 3'b111, 0,  2, 3, 3};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_dest = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_err", err_cnt, 0);
        last_sel = 0;

`ifdef DEMUX_DISPATCH_RR_EN
        for (int i = 0; i < 6; i++) begin
            q.push_back({2'(i), oh(i % NO)});
            send(2'(i), 2'($urandom_range(0, 3)));
            check("rr_sel", sel, i % NO);
            check("rr_valid", out_valid, oh(i % NO));
            out_ready = '1;
            @(posedge clk);
            #1;
            out_ready = '0;
            check("rr_idle", busy, 0);
        end
        check("rr_err", err_cnt, 0);
`else
        for (int i = 0; i < 13; i++) begin
            check("pre_ready", in_ready, 1);
            if (vt[i].kind == 0) q.push_back({vt[i].data, oh(vt[i].dest)});
            send(vt[i].data, vt[i].dest);
            if (vt[i].kind == 2) begin
                check("err_ready", in_ready, 1);
                check("err_valid", out_valid, 0);
                check("err_sel", sel, last_sel);
            end else begin
                len = 0;
                for (int k = 0; k < 20; k++) begin
                    if (out_valid == 0) break;
                    if (k == 0) check("offer_valid", out_valid, oh(vt[i].dest));
                    if (k == 0) check("offer_ready", in_ready, 0);
                    if (vt[i].rdy_at >= 0 && k >= vt[i].rdy_at) out_ready = vt[i].mask;
                    len++;
                    @(posedge clk);
                    #1;
                end
                out_ready = '0;
                check("offer_len", len, vt[i].len);
                last_sel = vt[i].dest;
            end
            check("drop_cnt", drop_cnt, vt[i].drops);
            check("err_cnt", err_cnt, vt[i].errs);
            check("post_ready", in_ready, 1);
        end
`endif

        // reset while an item is being offered discards it without counting
        send(2'd1, 2'd1);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_ready", in_ready, 1);
        check("mrst_sel", sel, 0);
        check("mrst_drop", drop_cnt, 0);
        check("mrst_err", err_cnt, 0);

        q.push_back({2'd2, oh(0)});
        send(2'd2, 2'd0);
        check("post_rst_data", out_data, 2);
        out_ready = 3'b001;
        @(posedge clk);
        #1;
        out_ready = '0;
        check("post_rst_idle", busy, 0);
        check("sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
